// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one main-memory port among cache DMA requesters.
// Write-backs hold the grant for the whole block; reads issue once and collect beats.
module mem_arbiter #(
  parameter int unsigned num_req_p        = 4,
  parameter int unsigned dma_data_width_p = 2,
  parameter int unsigned block_width_p    = 4
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic [num_req_p-1:0]                   req_valid_i,
  input  logic [num_req_p-1:0]                   req_we_i,
  input  logic [num_req_p*32-1:0]                req_addr_i,
  input  logic [num_req_p*dma_data_width_p*32-1:0] req_wdata_i,
  output logic [num_req_p-1:0]                   req_ready_o,
  output logic [num_req_p-1:0]                   rsp_valid_o,
  output logic [dma_data_width_p*32-1:0]         rsp_data_o,
  output logic [num_req_p-1:0]                   grant_o,
  output logic                                   mem_valid_o,
  input  logic                                   mem_ready_i,
  output logic                                   mem_we_o,
  output logic [31:0]                            mem_addr_o,
  output logic [dma_data_width_p*32-1:0]         mem_wdata_o,
  input  logic                                   mem_valid_i,
  input  logic [dma_data_width_p*32-1:0]         mem_data_i
);

  localparam int unsigned beats_lp  = block_width_p / dma_data_width_p;
  localparam int unsigned beat_w_lp = (beats_lp > 1) ? $clog2(beats_lp) : 1;
  localparam int unsigned idx_w_lp  = $clog2(num_req_p);
  localparam int unsigned data_w_lp = dma_data_width_p * 32;
  localparam logic [beat_w_lp-1:0] beat_last_lp = beat_w_lp'(beats_lp - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT} state_e;

  state_e                state_r, state_n;
  logic [beat_w_lp-1:0]  beat_r, beat_n;
  logic [idx_w_lp-1:0]   last_r, last_n;
  logic [idx_w_lp-1:0]   owner_r, owner_n;

  logic [idx_w_lp-1:0]   pick, cand;
  logic                  found;
  logic                  own_valid, own_we, hs;
  logic [31:0]           own_addr;
  logic [data_w_lp-1:0]  own_wdata;

  assign own_valid  = req_valid_i[owner_r];
  assign own_we     = req_we_i[owner_r];
  assign own_addr   = req_addr_i[32'(owner_r) * 32 +: 32];
  assign own_wdata  = req_wdata_i[32'(owner_r) * data_w_lp +: data_w_lp];
  assign rsp_data_o = mem_data_i;

  // First requesting index searching upward circularly from the last owner + 1.
  always_comb begin
    pick  = last_r;
    cand  = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= num_req_p; k++) begin
      cand = idx_w_lp'((32'(last_r) + k) % num_req_p);
      if (!found && req_valid_i[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_n     = state_r;
    beat_n      = beat_r;
    last_n      = last_r;
    owner_n     = owner_r;
    hs          = 1'b0;
    mem_valid_o = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    req_ready_o = '0;
    rsp_valid_o = '0;
    grant_o     = '0;

    case (state_r)
      IDLE: begin
        if (found) begin
          owner_n = pick;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        grant_o[owner_r]     = 1'b1;
        mem_valid_o          = own_valid;
        mem_we_o             = own_we;
        mem_addr_o           = own_addr;
        mem_wdata_o          = own_wdata;
        hs                   = own_valid & mem_ready_i;
        req_ready_o[owner_r] = hs;
        if (hs) begin
          if (own_we) begin
            if (beat_r == beat_last_lp) begin
              beat_n  = '0;
              last_n  = owner_r;
              state_n = IDLE;
            end else begin
              beat_n = beat_r + beat_w_lp'(1);
            end
          end else begin
            beat_n  = '0;
            state_n = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        grant_o[owner_r]     = 1'b1;
        rsp_valid_o[owner_r] = mem_valid_i;
        if (mem_valid_i) begin
          if (beat_r == beat_last_lp) begin
            beat_n  = '0;
            last_n  = owner_r;
            state_n = IDLE;
          end else begin
            beat_n = beat_r + beat_w_lp'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Reset abandons any transaction immediately: no handshake leaks out this cycle.
    if (reset_i) begin
      mem_valid_o = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      req_ready_o = '0;
      rsp_valid_o = '0;
      grant_o     = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= IDLE;
      beat_r  <= '0;
      last_r  <= idx_w_lp'(num_req_p - 1);
      owner_r <= '0;
    end else begin
      state_r <= state_n;
      beat_r  <= beat_n;
      last_r  <= last_n;
      owner_r <= owner_n;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scenarios plus random traffic for mem_arbiter, checked each cycle
// against a transaction-level model of owner, remaining beats and round-robin pointer.
module tb_mem_arbiter;

  localparam int N      = 4;
  localparam int DWORDS = 2;
  localparam int BW     = 4;
  localparam int BEATS  = BW / DWORDS;
  localparam int DW     = DWORDS * 32;

  logic            clk;
  logic            reset;
  logic [N-1:0]    req_valid, req_we;
  logic [N*32-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    req_ready_o, rsp_valid_o, grant_o;
  logic [DW-1:0]   rsp_data_o;
  logic            mem_valid_o, mem_we_o;
  logic            mem_ready, mem_valid_in;
  logic [31:0]     mem_addr_o;
  logic [DW-1:0]   mem_wdata_o, mem_data_in;

  mem_arbiter #(.num_req_p(N), .dma_data_width_p(DWORDS), .block_width_p(BW)) dut (
    .clk_i(clk), .reset_i(reset),
    .req_valid_i(req_valid), .req_we_i(req_we), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_ready_o(req_ready_o), .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o),
    .grant_o(grant_o), .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_valid_i(mem_valid_in), .mem_data_i(mem_data_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the port, whether the address phase is pending, beats left.
  int m_owner = -1;
  int m_last  = N - 1;
  int m_beats = 0;
  bit m_addr_phase = 1'b0;

  // Observed-behaviour bookkeeping and auto-responders.
  logic [N-1:0] glog[$];
  logic [N-1:0] prev_grant = '0;
  int           rsp_cnt[N];
  int           hs_cnt = 0;
  logic [31:0]  hs_addr = '0;
  int           rd_pending = 0;
  bit           auto_mem = 1'b0;
  bit           auto_drop = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_obs();
    glog.delete();
    for (int i = 0; i < N; i++) rsp_cnt[i] = 0;
    hs_cnt  = 0;
    hs_addr = '0;
  endtask

  task automatic set_req(input int i, input logic v, input logic we,
                         input logic [31:0] a, input logic [DW-1:0] d);
    req_valid[i]            = v;
    req_we[i]               = we;
    req_addr[32*i +: 32]    = a;
    req_wdata[DW*i +: DW]   = d;
  endtask

  // Check outputs for the current inputs, advance the model, clock once.
  task automatic cycle();
    logic [N-1:0] e_grant, e_ready, e_rsp, obs_ready;
    logic         e_mv, obs_rd_hs;
    bit           fnd;
    int           c;
    #1;
    e_grant = '0; e_ready = '0; e_rsp = '0; e_mv = 1'b0;
    if (!reset && m_owner >= 0) begin
      e_grant[m_owner] = 1'b1;
      if (m_addr_phase) begin
        e_mv = req_valid[m_owner];
        e_ready[m_owner] = e_mv & mem_ready;
      end else begin
        e_rsp[m_owner] = mem_valid_in;
      end
    end
    chk("grant", 64'(grant_o), 64'(e_grant));
    chk("mem_valid", 64'(mem_valid_o), 64'(e_mv));
    chk("req_ready", 64'(req_ready_o), 64'(e_ready));
    chk("rsp_valid", 64'(rsp_valid_o), 64'(e_rsp));
    chk("rsp_data", rsp_data_o, mem_data_in);
    if (e_mv) begin
      chk("mem_addr", 64'(mem_addr_o), 64'(req_addr[32*m_owner +: 32]));
      chk("mem_we", 64'(mem_we_o), 64'(req_we[m_owner]));
      chk("mem_wdata", mem_wdata_o, req_wdata[DW*m_owner +: DW]);
    end

    if (grant_o != '0 && prev_grant == '0) glog.push_back(grant_o);
    prev_grant = grant_o;
    for (int i = 0; i < N; i++) if (rsp_valid_o[i]) rsp_cnt[i]++;
    if (mem_valid_o && mem_ready) begin
      hs_cnt++;
      hs_addr = mem_addr_o;
    end
    obs_ready = req_ready_o;
    obs_rd_hs = mem_valid_o & mem_ready & ~mem_we_o;

    if (reset) begin
      m_owner = -1;
      m_last  = N - 1;
    end else if (m_owner < 0) begin
      fnd = 1'b0;
      for (int k = 1; k <= N; k++) begin
        c = (m_last + k) % N;
        if (!fnd && req_valid[c]) begin
          fnd = 1'b1;
          m_owner = c;
          m_addr_phase = 1'b1;
          m_beats = BEATS;
        end
      end
    end else if (m_addr_phase) begin
      if (req_valid[m_owner] && mem_ready) begin
        if (req_we[m_owner]) begin
          m_beats--;
          if (m_beats == 0) begin
            m_last = m_owner;
            m_owner = -1;
          end
        end else begin
          m_addr_phase = 1'b0;
          m_beats = BEATS;
        end
      end
    end else if (mem_valid_in) begin
      m_beats--;
      if (m_beats == 0) begin
        m_last = m_owner;
        m_owner = -1;
      end
    end

    @(posedge clk);
    @(negedge clk);

    if (reset) rd_pending = 0;
    else begin
      if (auto_mem && mem_valid_in && rd_pending > 0) rd_pending--;
      if (obs_rd_hs) rd_pending += BEATS;
    end
    if (auto_mem) mem_valid_in = (rd_pending > 0);
    mem_data_in = {$urandom, $urandom};
    if (auto_drop)
      for (int i = 0; i < N; i++)
        if (obs_ready[i] && !req_we[i]) req_valid[i] = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    mem_ready = 1'b0; mem_valid_in = 1'b0; mem_data_in = '0;
    clear_obs();
    @(negedge clk);
    cycle();
    cycle();
    reset = 1'b0;
    #1;
    chk("rst_outputs", 64'({grant_o, req_ready_o, rsp_valid_o, mem_valid_o}), 64'(0));

    // Scenario 1: single read from requester 0
    clear_obs();
    auto_mem = 1'b1; auto_drop = 1'b1; mem_ready = 1'b1;
    set_req(0, 1'b1, 1'b0, 32'h40, '0);
    cycle();
    chk("s1_grant", 64'(grant_o), 64'(4'b0001));
    repeat (4) cycle();
    chk("s1_rsp_cnt", 64'(rsp_cnt[0]), 64'(2));
    chk("s1_hs_cnt", 64'(hs_cnt), 64'(1));
    chk("s1_hs_addr", 64'(hs_addr), 64'h40);
    chk("s1_idle", 64'(grant_o), 64'(0));

    // Scenario 2: simultaneous reads from 1 and 3
    clear_obs();
    set_req(1, 1'b1, 1'b0, 32'h100, '0);
    set_req(3, 1'b1, 1'b0, 32'h300, '0);
    repeat (12) cycle();
    chk("s2_nglog", 64'(glog.size()), 64'(2));
    chk("s2_first", 64'(glog[0]), 64'(4'b0010));
    chk("s2_second", 64'(glog[1]), 64'(4'b1000));
    chk("s2_rsp1", 64'(rsp_cnt[1]), 64'(2));
    chk("s2_rsp3", 64'(rsp_cnt[3]), 64'(2));

    // Scenario 3: write-back from 2 is not interleaved with a read from 0
    clear_obs();
    set_req(2, 1'b1, 1'b1, 32'h80, 64'hA5A5_0000_1111_2222);
    cycle();
    set_req(0, 1'b1, 1'b0, 32'h400, '0);
    cycle();
    chk("s3_hold", 64'(grant_o), 64'(4'b0100));
    set_req(2, 1'b1, 1'b1, 32'h88, 64'h5A5A_3333_4444_5555);
    cycle();
    set_req(2, 1'b0, 1'b0, 32'h0, '0);
    chk("s3_gap", 64'(grant_o), 64'(0));
    chk("s3_hs_cnt", 64'(hs_cnt), 64'(2));
    chk("s3_hs_addr", 64'(hs_addr), 64'h88);
    cycle();
    chk("s3_next", 64'(grant_o), 64'(4'b0001));
    repeat (4) cycle();
    chk("s3_idle", 64'(grant_o), 64'(0));

    // Scenario 4: memory back-pressure in ISSUE
    clear_obs();
    mem_ready = 1'b0;
    set_req(1, 1'b1, 1'b0, 32'h200, '0);
    cycle();
    repeat (5) begin
      cycle();
      chk("s4_mv", 64'(mem_valid_o), 64'(1));
      chk("s4_addr", 64'(mem_addr_o), 64'h200);
      chk("s4_ready", 64'(req_ready_o), 64'(0));
    end
    mem_ready = 1'b1;
    repeat (4) cycle();
    chk("s4_idle", 64'(grant_o), 64'(0));

    // Scenario 5: reset in RD_WAIT drops the trailing beat
    clear_obs();
    auto_mem = 1'b0;
    mem_valid_in = 1'b0;
    set_req(0, 1'b1, 1'b0, 32'h500, '0);
    cycle();
    cycle();
    mem_valid_in = 1'b1;
    cycle();
    reset = 1'b1;
    mem_valid_in = 1'b0;
    cycle();
    reset = 1'b0;
    mem_valid_in = 1'b1;
    cycle();
    mem_valid_in = 1'b0;
    chk("s5_rsp_cnt", 64'(rsp_cnt[0]), 64'(1));
    chk("s5_idle", 64'(grant_o), 64'(0));

    // Scenario 6: all four hold reads continuously
    clear_obs();
    auto_mem = 1'b1; auto_drop = 1'b0; rd_pending = 0;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, 32'(32'h1000 * (i + 1)), '0);
    for (int k = 0; k < 80 && glog.size() < 5; k++) cycle();
    chk("s6_nglog", 64'(glog.size()), 64'(5));
    chk("s6_g0", 64'(glog[0]), 64'(4'b0001));
    chk("s6_g1", 64'(glog[1]), 64'(4'b0010));
    chk("s6_g2", 64'(glog[2]), 64'(4'b0100));
    chk("s6_g3", 64'(glog[3]), 64'(4'b1000));
    chk("s6_g4", 64'(glog[4]), 64'(4'b0001));
    req_valid = '0;
    repeat (6) cycle();
    chk("s6_idle", 64'(grant_o), 64'(0));

    // Random traffic, including stray beats and occasional resets
    auto_mem = 1'b0; auto_drop = 1'b0;
    repeat (400) begin
      reset        = ($urandom_range(0, 49) == 0);
      req_valid    = N'($urandom);
      req_we       = N'($urandom);
      for (int i = 0; i < N; i++) begin
        req_addr[32*i +: 32]  = $urandom;
        req_wdata[DW*i +: DW] = {$urandom, $urandom};
      end
      mem_ready    = ($urandom_range(0, 3) != 0);
      mem_valid_in = 1'($urandom);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
